stage_id: RTL and testbench
===========================

STAGE_ID -- requirements
Module: stage_id

Interface
REQ-001 Clk  in  1  system clock; all state updates on rising edge.
REQ-002 Clrn  in  1  asynchronous, active-low reset.
REQ-003 IFout_PC4  in  32  PC+4 of the fetched instruction.
REQ-004 IFout_Inst  in  32  fetched instruction word.
REQ-005 MEM_PCSrc  in  1  branch/jump taken; flush request.
REQ-006 WB_RegWrite  in  1  write-back enable.
REQ-007 WB_WriteReg  in  5  write-back destination register.
REQ-008 WB_WriteData  in  32  write-back data.
REQ-009 IDout_PC4  out  32  registered PC+4.
REQ-010 IDout_RsData, IDout_RtData  out  32 each  registered operand values.
REQ-011 IDout_Imm  out  32  registered sign-extended imm16.
REQ-012 IDout_Jtarg  out  32  registered jump target {IFout_PC4[31:28], Inst[25:0], 2'b00}.
REQ-013 IDout_Rt, IDout_Rd  out  5 each  registered register indices.
REQ-014 IDout_RegWrite, IDout_MemtoReg, IDout_MemRead, IDout_MemWrite, IDout_Branch, IDout_Jump, IDout_ALUSrc, IDout_RegDst  out  1 each  registered control bits.
REQ-015 IDout_ALUOp  out  3  registered ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-016 ID_Stall  out  1  combinational load-use stall request to the fetch side.
REQ-017 IDout_Illegal  out  1  registered one-cycle flag for an undecodable opcode.

Function
REQ-018 Register file: 32x32. Register 0 always reads 0. Register 0 writes are ignored.
REQ-019 Register file write: rising edge when WB_RegWrite=1 and WB_WriteReg!=0.
REQ-020 Read bypass: when WB_RegWrite=1, WB_WriteReg!=0 and WB_WriteReg equals rs/rt, the read returns WB_WriteData in the same cycle.
REQ-021 Decode field rs=Inst[25:21].
REQ-022 Decode field rt=Inst[20:16].
REQ-023 Decode field rd=Inst[15:11].
REQ-024 Decode field imm=Inst[15:0], sign-extended to 32 bits.
REQ-025 R-type (op 000000) funct 100000/100010/100100/100101/101010 -> RegWrite, RegDst, ALUOp add/sub/and/or/slt.
REQ-026 lw (100011) -> RegWrite, MemtoReg, MemRead, ALUSrc, add.
REQ-027 sw (101011) -> MemWrite, ALUSrc, add.
REQ-028 beq (000100) -> Branch, sub.
REQ-029 addi (001000) -> RegWrite, ALUSrc, add.
REQ-030 j (000010) -> Jump.
REQ-031 Inst=32'h0 is a NOP: all control 0, IDout_Illegal=0.
REQ-032 Any other opcode/funct is illegal: all control 0, IDout_Illegal=1 for one cycle.
REQ-033 ID_Stall=1 when all hold: IDout_MemRead=1, IDout_Rt!=0, and IDout_Rt equals current rs or rt (rt compared only for R-type, beq, sw).
REQ-034 Bubble: on a rising edge with ID_Stall=1, all control bits, IDout_Illegal and IDout_ALUOp load 0. Data fields load the current decode.
REQ-035 Flush: on a rising edge with MEM_PCSrc=1, apply the REQ-034 bubble. Flush has priority over stall and normal decode.
REQ-036 Latency: one cycle from IFout_Inst to IDout_*. The stall path ID_Stall is same-cycle combinational.
REQ-037 Stall clears one cycle after assertion, because the bubble sets IDout_MemRead=0.

Reset
REQ-038 Clrn=0: every IDout_* register, including IDout_PC4, clears to 0, and all 32 registers clear to 0.
REQ-039 Reset is immediate, with no clock needed. ID_Stall=0 during reset.
REQ-040 Reset asserted mid-pipeline discards pending decode. The first edge after release decodes IFout_Inst normally.

Verification
REQ-041 Reset: Clrn=0 mid-run -> all IDout_* =0 at once; reading $5 after release -> 0.
REQ-042 Decode: Inst=32'h012A4020 (add $8,$9,$10), $9=3, $10=4 -> next edge: RsData=3, RtData=4, Rd=8, RegWrite=1, RegDst=1, ALUOp=000.
REQ-043 Bypass: WB writes $9=32'hDEAD in the same cycle lw $2,0($9) decodes -> IDout_RsData=32'hDEAD, IDout_Imm=0.
REQ-044 Load-use: lw $2,0($1) then add $3,$2,$2 -> ID_Stall=1 for exactly one cycle; ID/EX holds zero control for that cycle; add decodes on the following edge.
REQ-045 Flush: MEM_PCSrc=1 while decoding sw -> IDout_MemWrite=0; flush together with stall -> bubble, no illegal flag.
REQ-046 Illegal/sign: Inst=32'hFC000000 -> IDout_Illegal=1 for one cycle, then 0. addi with imm 16'h8000 -> IDout_Imm=32'hFFFF8000. A write to $0 followed by a read of $0 -> 0.

Source files
------------

// File: rtl/stage_id.sv
// stage_id -- instruction decode stage of a 5-stage MIPS-subset pipeline.
//
// Holds the 32x32 register file (with a same-cycle write-back bypass) and
// decodes the fetched instruction into operand values, immediates, register
// indices and control bits. It also detects load-use hazards against the
// instruction currently sitting in the ID/EX register.
//
// Ports
//   Clk, Clrn               clock (rising edge), asynchronous active-low reset
//   IFout_PC4, IFout_Inst   PC+4 and instruction word from fetch
//   MEM_PCSrc               taken branch/jump: flush the decode into a bubble
//   WB_RegWrite/WriteReg/WriteData   register file write port
//   IDout_*                 registered ID/EX pipeline register contents
//   ID_Stall                combinational load-use stall request to fetch
module stage_id (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] IFout_PC4,
  input  logic [31:0] IFout_Inst,
  input  logic        MEM_PCSrc,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  output logic [31:0] IDout_PC4,
  output logic [31:0] IDout_RsData,
  output logic [31:0] IDout_RtData,
  output logic [31:0] IDout_Imm,
  output logic [31:0] IDout_Jtarg,
  output logic [4:0]  IDout_Rt,
  output logic [4:0]  IDout_Rd,
  output logic        IDout_RegWrite,
  output logic        IDout_MemtoReg,
  output logic        IDout_MemRead,
  output logic        IDout_MemWrite,
  output logic        IDout_Branch,
  output logic        IDout_Jump,
  output logic        IDout_ALUSrc,
  output logic        IDout_RegDst,
  output logic [2:0]  IDout_ALUOp,
  output logic        ID_Stall,
  output logic        IDout_Illegal
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } aluop_e;

  typedef struct packed {
    logic   reg_write;
    logic   mem_to_reg;
    logic   mem_read;
    logic   mem_write;
    logic   branch;
    logic   jump;
    logic   alu_src;
    logic   reg_dst;
    aluop_e alu_op;
    logic   illegal;
  } ctrl_t;

  // Instruction fields
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = IFout_Inst[31:26];
  assign funct = IFout_Inst[5:0];
  assign rs    = IFout_Inst[25:21];
  assign rt    = IFout_Inst[20:16];
  assign rd    = IFout_Inst[15:11];

  // Register file. Entry 0 is never written, and reads of index 0 are forced
  // to zero as well so the read path does not depend on that.
  logic [31:0] regs_q [32];

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (WB_RegWrite && (WB_WriteReg != '0)) begin
      regs_q[WB_WriteReg] <= WB_WriteData;
    end
  end

  logic [31:0] rs_data;
  logic [31:0] rt_data;

  always_comb begin
    rs_data = '0;
    if (rs != '0) begin
      if (WB_RegWrite && (WB_WriteReg == rs)) rs_data = WB_WriteData;
      else                                    rs_data = regs_q[rs];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt != '0) begin
      if (WB_RegWrite && (WB_WriteReg == rt)) rt_data = WB_WriteData;
      else                                    rt_data = regs_q[rt];
    end
  end

  // Control decode
  ctrl_t ctrl_dec;

  always_comb begin
    ctrl_dec = '0;
    case (op)
      OP_RTYPE: begin
        // The all-zero word is the canonical NOP and decodes to no control.
        if (IFout_Inst != '0) begin
          ctrl_dec.reg_write = 1'b1;
          ctrl_dec.reg_dst   = 1'b1;
          case (funct)
            FN_ADD:  ctrl_dec.alu_op = ALU_ADD;
            FN_SUB:  ctrl_dec.alu_op = ALU_SUB;
            FN_AND:  ctrl_dec.alu_op = ALU_AND;
            FN_OR:   ctrl_dec.alu_op = ALU_OR;
            FN_SLT:  ctrl_dec.alu_op = ALU_SLT;
            default: begin
              ctrl_dec         = '0;
              ctrl_dec.illegal = 1'b1;
            end
          endcase
        end
      end
      OP_LW: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = ALU_ADD;
      end
      OP_J: begin
        ctrl_dec.jump = 1'b1;
      end
      default: begin
        ctrl_dec.illegal = 1'b1;
      end
    endcase
  end

  // ID/EX pipeline register
  logic [31:0] pc4_q,   pc4_d;
  logic [31:0] rsd_q,   rsd_d;
  logic [31:0] rtd_q,   rtd_d;
  logic [31:0] imm_q,   imm_d;
  logic [31:0] jtarg_q, jtarg_d;
  logic [4:0]  rt_q,    rt_d;
  logic [4:0]  rd_q,    rd_d;
  ctrl_t       ctrl_q,  ctrl_d;

  // Load-use hazard: the load in ID/EX writes a register this instruction
  // reads. rt is only a source operand for R-type, beq and sw.
  logic uses_rt;
  logic stall;

  assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  assign stall   = ctrl_q.mem_read && (rt_q != '0) &&
                   ((rt_q == rs) || (uses_rt && (rt_q == rt)));

  always_comb begin
    pc4_d   = IFout_PC4;
    rsd_d   = rs_data;
    rtd_d   = rt_data;
    imm_d   = {{16{IFout_Inst[15]}}, IFout_Inst[15:0]};
    jtarg_d = {IFout_PC4[31:28], IFout_Inst[25:0], 2'b00};
    rt_d    = rt;
    rd_d    = rd;
    // Flush and stall both insert a bubble: data fields still load, only the
    // control word (including the illegal flag) is suppressed.
    ctrl_d  = (MEM_PCSrc || stall) ? '0 : ctrl_dec;
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pc4_q   <= '0;
      rsd_q   <= '0;
      rtd_q   <= '0;
      imm_q   <= '0;
      jtarg_q <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      pc4_q   <= pc4_d;
      rsd_q   <= rsd_d;
      rtd_q   <= rtd_d;
      imm_q   <= imm_d;
      jtarg_q <= jtarg_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign IDout_PC4      = pc4_q;
  assign IDout_RsData   = rsd_q;
  assign IDout_RtData   = rtd_q;
  assign IDout_Imm      = imm_q;
  assign IDout_Jtarg    = jtarg_q;
  assign IDout_Rt       = rt_q;
  assign IDout_Rd       = rd_q;
  assign IDout_RegWrite = ctrl_q.reg_write;
  assign IDout_MemtoReg = ctrl_q.mem_to_reg;
  assign IDout_MemRead  = ctrl_q.mem_read;
  assign IDout_MemWrite = ctrl_q.mem_write;
  assign IDout_Branch   = ctrl_q.branch;
  assign IDout_Jump     = ctrl_q.jump;
  assign IDout_ALUSrc   = ctrl_q.alu_src;
  assign IDout_RegDst   = ctrl_q.reg_dst;
  assign IDout_ALUOp    = ctrl_q.alu_op;
  assign IDout_Illegal  = ctrl_q.illegal;
  assign ID_Stall       = stall;

endmodule

// File: tb/tb_stage_id.sv
// Testbench for stage_id: directed scenarios plus a randomized run, all
// checked against a mnemonic-level reference model of the decode stage.
module tb_stage_id;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [31:0] IFout_PC4, IFout_Inst;
  logic        MEM_PCSrc, WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic [31:0] IDout_PC4, IDout_RsData, IDout_RtData, IDout_Imm, IDout_Jtarg;
  logic [4:0]  IDout_Rt, IDout_Rd;
  logic        IDout_RegWrite, IDout_MemtoReg, IDout_MemRead, IDout_MemWrite;
  logic        IDout_Branch, IDout_Jump, IDout_ALUSrc, IDout_RegDst;
  logic [2:0]  IDout_ALUOp;
  logic        ID_Stall, IDout_Illegal;

  stage_id dut (
    .Clk(Clk), .Clrn(Clrn), .IFout_PC4(IFout_PC4), .IFout_Inst(IFout_Inst),
    .MEM_PCSrc(MEM_PCSrc), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_WriteData(WB_WriteData), .IDout_PC4(IDout_PC4), .IDout_RsData(IDout_RsData),
    .IDout_RtData(IDout_RtData), .IDout_Imm(IDout_Imm), .IDout_Jtarg(IDout_Jtarg),
    .IDout_Rt(IDout_Rt), .IDout_Rd(IDout_Rd), .IDout_RegWrite(IDout_RegWrite),
    .IDout_MemtoReg(IDout_MemtoReg), .IDout_MemRead(IDout_MemRead),
    .IDout_MemWrite(IDout_MemWrite), .IDout_Branch(IDout_Branch), .IDout_Jump(IDout_Jump),
    .IDout_ALUSrc(IDout_ALUSrc), .IDout_RegDst(IDout_RegDst), .IDout_ALUOp(IDout_ALUOp),
    .ID_Stall(ID_Stall), .IDout_Illegal(IDout_Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] pc4, rsd, rtd, imm, jtarg;
    logic [4:0]  rt, rd;
    logic        regwrite, memtoreg, memread, memwrite, branch, jump, alusrc, regdst;
    logic [2:0]  aluop;
    logic        illegal;
  } out_t;

  typedef enum {M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_SLT,
                M_LW, M_SW, M_BEQ, M_ADDI, M_J, M_ILL} mn_t;

  out_t        exp_q, exp_nx;
  logic        exp_stall;
  logic [31:0] mreg [32];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic out_t dut_out();
    out_t o;
    o = '{IDout_PC4, IDout_RsData, IDout_RtData, IDout_Imm, IDout_Jtarg,
          IDout_Rt, IDout_Rd, IDout_RegWrite, IDout_MemtoReg, IDout_MemRead,
          IDout_MemWrite, IDout_Branch, IDout_Jump, IDout_ALUSrc, IDout_RegDst,
          IDout_ALUOp, IDout_Illegal};
    return o;
  endfunction

  function automatic mn_t classify(input logic [31:0] inst);
    logic [5:0] opc, fn;
    opc = inst[31:26];
    fn  = inst[5:0];
    if (inst == 32'h0) return M_NOP;
    case (opc)
      6'h00: case (fn)
               6'h20: return M_ADD;
               6'h22: return M_SUB;
               6'h24: return M_AND;
               6'h25: return M_OR;
               6'h2A: return M_SLT;
               default: return M_ILL;
             endcase
      6'h23: return M_LW;
      6'h2B: return M_SW;
      6'h04: return M_BEQ;
      6'h08: return M_ADDI;
      6'h02: return M_J;
      default: return M_ILL;
    endcase
  endfunction

  // Architectural register read as seen by decode, including the write-back bypass.
  function automatic logic [31:0] rdreg(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (WB_RegWrite && WB_WriteReg == idx) return WB_WriteData;
    return mreg[idx];
  endfunction

  task automatic model_reset();
    exp_q = '0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
  endtask

  // Apply inputs and compute what the next edge should produce.
  task automatic drive(input logic [31:0] inst, input logic [31:0] pc4, input logic pcsrc,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
    mn_t mn;
    logic [4:0] rs, rt;
    logic uses_rt;
    IFout_Inst = inst; IFout_PC4 = pc4; MEM_PCSrc = pcsrc;
    WB_RegWrite = we; WB_WriteReg = wr; WB_WriteData = wd;
    mn = classify(inst);
    rs = inst[25:21];
    rt = inst[20:16];
    uses_rt = (inst[31:26] == 6'h00) || mn == M_BEQ || mn == M_SW;
    exp_stall = exp_q.memread && exp_q.rt != 0 &&
                (exp_q.rt == rs || (uses_rt && exp_q.rt == rt));
    exp_nx = '0;
    exp_nx.pc4   = pc4;
    exp_nx.rsd   = rdreg(rs);
    exp_nx.rtd   = rdreg(rt);
    exp_nx.imm   = 32'($signed(inst[15:0]));
    exp_nx.jtarg = (pc4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
    exp_nx.rt    = rt;
    exp_nx.rd    = inst[15:11];
    if (!(pcsrc || exp_stall)) begin
      case (mn)
        M_ADD:  begin exp_nx.regwrite = 1; exp_nx.regdst = 1; exp_nx.aluop = 3'd0; end
        M_SUB:  begin exp_nx.regwrite = 1; exp_nx.regdst = 1; exp_nx.aluop = 3'd1; end
        M_AND:  begin exp_nx.regwrite = 1; exp_nx.regdst = 1; exp_nx.aluop = 3'd2; end
        M_OR:   begin exp_nx.regwrite = 1; exp_nx.regdst = 1; exp_nx.aluop = 3'd3; end
        M_SLT:  begin exp_nx.regwrite = 1; exp_nx.regdst = 1; exp_nx.aluop = 3'd4; end
        M_LW:   begin exp_nx.regwrite = 1; exp_nx.memtoreg = 1; exp_nx.memread = 1; exp_nx.alusrc = 1; end
        M_SW:   begin exp_nx.memwrite = 1; exp_nx.alusrc = 1; end
        M_BEQ:  begin exp_nx.branch = 1; exp_nx.aluop = 3'd1; end
        M_ADDI: begin exp_nx.regwrite = 1; exp_nx.alusrc = 1; end
        M_J:    exp_nx.jump = 1;
        M_ILL:  exp_nx.illegal = 1;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    exp_q = exp_nx;
    if (WB_RegWrite && WB_WriteReg != 0) mreg[WB_WriteReg] = WB_WriteData;
    #1;
  endtask

  task automatic test_reset();
    Clrn = 1'b0;
    drive(32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
    model_reset();
    vectors++;
    if (dut_out() !== exp_q || ID_Stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_initial: got %h stall %b want %h stall 0", dut_out(), ID_Stall, exp_q);
    end
    @(negedge Clk); Clrn = 1'b1;
    // write $5, then leave a load pending in ID/EX
    drive(32'h0, 32'h4, 0, 1, 5'd5, 32'h55);
    tick();
    drive(32'h8C250010, 32'h8, 0, 0, 5'd0, 32'h0);   // lw $5,16($1)
    tick();
    vectors++;
    if (dut_out() !== exp_q) begin
      miscompares++;
      $display("FAIL reset_preload: got %h want %h", dut_out(), exp_q);
    end
    drive(32'h00A00820, 32'hC, 0, 0, 5'd0, 32'h0);   // add $1,$5,$0
    Clrn = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (dut_out() !== exp_q || ID_Stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got %h stall %b want %h stall 0", dut_out(), ID_Stall, exp_q);
    end
    @(negedge Clk); Clrn = 1'b1;
    drive(32'h00A00820, 32'hC, 0, 0, 5'd0, 32'h0);
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_RsData !== 32'h0 || IDout_RegWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_read5: got %h want %h", dut_out(), exp_q);
    end
  endtask

  task automatic test_decode();
    drive(32'h0, 32'h10, 0, 1, 5'd9, 32'd3);  tick();
    drive(32'h0, 32'h14, 0, 1, 5'd10, 32'd4); tick();
    drive(32'h012A4020, 32'h18, 0, 0, 5'd0, 32'h0);   // add $8,$9,$10
    tick();
    vectors++;
    if (dut_out() !== exp_q) begin
      miscompares++;
      $display("FAIL decode_add_model: got %h want %h", dut_out(), exp_q);
    end
    vectors++;
    if ({IDout_RsData, IDout_RtData, IDout_Rd, IDout_RegWrite, IDout_RegDst, IDout_ALUOp}
        !== {32'd3, 32'd4, 5'd8, 1'b1, 1'b1, 3'b000}) begin
      miscompares++;
      $display("FAIL decode_add_fields: got rs %h rt %h rd %0d rw %b rdst %b op %b want 3 4 8 1 1 000",
               IDout_RsData, IDout_RtData, IDout_Rd, IDout_RegWrite, IDout_RegDst, IDout_ALUOp);
    end
  endtask

  task automatic test_bypass();
    drive(32'h8D220000, 32'h1C, 0, 1, 5'd9, 32'hDEAD);   // lw $2,0($9)
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_RsData !== 32'hDEAD || IDout_Imm !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass: got %h want %h", dut_out(), exp_q);
    end
  endtask

  task automatic test_load_use();
    drive(32'h0, 32'h20, 0, 0, 5'd0, 32'h0); tick();
    drive(32'h8C220000, 32'h24, 0, 0, 5'd0, 32'h0);      // lw $2,0($1)
    tick();
    drive(32'h00421820, 32'h28, 0, 0, 5'd0, 32'h0);      // add $3,$2,$2
    vectors++;
    if (ID_Stall !== exp_stall || ID_Stall !== 1'b1) begin
      miscompares++;
      $display("FAIL loaduse_stall_on: got %b want 1", ID_Stall);
    end
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_RegWrite !== 1'b0 || IDout_MemRead !== 1'b0) begin
      miscompares++;
      $display("FAIL loaduse_bubble: got %h want %h", dut_out(), exp_q);
    end
    drive(32'h00421820, 32'h28, 0, 0, 5'd0, 32'h0);      // held by fetch
    vectors++;
    if (ID_Stall !== exp_stall || ID_Stall !== 1'b0) begin
      miscompares++;
      $display("FAIL loaduse_stall_off: got %b want 0", ID_Stall);
    end
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_RegWrite !== 1'b1 || IDout_Rd !== 5'd3) begin
      miscompares++;
      $display("FAIL loaduse_resume: got %h want %h", dut_out(), exp_q);
    end
  endtask

  task automatic test_flush();
    drive(32'hACC50004, 32'h30, 1, 0, 5'd0, 32'h0);      // sw $5,4($6) flushed
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_MemWrite !== 1'b0 || IDout_Imm !== 32'h4) begin
      miscompares++;
      $display("FAIL flush_sw: got %h want %h", dut_out(), exp_q);
    end
    drive(32'h8C220000, 32'h34, 0, 0, 5'd0, 32'h0);      // lw $2,0($1)
    tick();
    drive(32'hFC400000, 32'h38, 1, 0, 5'd0, 32'h0);      // illegal, rs=$2, flushed
    vectors++;
    if (ID_Stall !== exp_stall || ID_Stall !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_stall_req: got %b want 1", ID_Stall);
    end
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_Illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stall_bubble: got %h want %h", dut_out(), exp_q);
    end
  endtask

  task automatic test_illegal_sign();
    drive(32'hFC000000, 32'h40, 0, 0, 5'd0, 32'h0);
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_Illegal !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_set: got %h want %h", dut_out(), exp_q);
    end
    drive(32'h0, 32'h44, 0, 0, 5'd0, 32'h0);
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_Illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear: got %h want %h", dut_out(), exp_q);
    end
    drive(32'h20048000, 32'h48, 0, 0, 5'd0, 32'h0);      // addi $4,$0,-32768
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_Imm !== 32'hFFFF8000) begin
      miscompares++;
      $display("FAIL addi_signext: got %h want %h", dut_out(), exp_q);
    end
    drive(32'h0, 32'h4C, 0, 1, 5'd0, 32'h1234);          // write to $0
    tick();
    drive(32'h00000820, 32'h50, 0, 0, 5'd0, 32'h0);      // add $1,$0,$0
    tick();
    vectors++;
    if (dut_out() !== exp_q || IDout_RsData !== 32'h0) begin
      miscompares++;
      $display("FAIL reg0_read: got %h want %h", dut_out(), exp_q);
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    logic [15:0] imm;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    fn  = fns[$urandom_range(0, 4)];
    case ($urandom_range(0, 9))
      0, 1: return {6'h00, rs, rt, rd, 5'd0, fn};
      2, 3: return {6'h23, rs, rt, imm};
      4:    return {6'h2B, rs, rt, imm};
      5:    return {6'h04, rs, rt, imm};
      6:    return {6'h08, rs, rt, imm};
      7:    return {6'h02, 26'($urandom)};
      8:    return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(gen_inst(), $urandom, ($urandom_range(0, 7) == 0), 1'($urandom),
            5'($urandom_range(0, 3)), $urandom);
      vectors++;
      if (ID_Stall !== exp_stall) begin
        miscompares++;
        $display("FAIL rand_stall[%0d]: got %b want %b", n, ID_Stall, exp_stall);
      end
      tick();
      vectors++;
      if (dut_out() !== exp_q) begin
        miscompares++;
        $display("FAIL rand_out[%0d]: got %h want %h", n, dut_out(), exp_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_bypass();
    test_load_use();
    test_flush();
    test_illegal_sign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
